// File: rtl/temp_multi_channel_monitor.sv
// Multi-channel temperature monitor: per-channel block averaging, threshold alarms and an
// auto-rotate / hold display selector. Define TEMP_MON_MINMAX_EN to build per-channel min/max tracking.

module temp_multi_channel_monitor #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 8,
    parameter int AVG_LOG2     = 2,
    parameter int DWELL_CYCLES = 25_000_000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [CH_W-1:0]     sample_ch,
    input  logic [DATA_W-1:0]   sample_data,
    input  logic                mode_btn,
    input  logic                next_btn,
    input  logic [DATA_W-1:0]   hi_thresh,
    input  logic [DATA_W-1:0]   lo_thresh,
    output logic [CH_W-1:0]     disp_ch,
    output logic [DATA_W-1:0]   disp_c,
    output logic [DATA_W+1:0]   disp_f,
    output logic                disp_valid,
    output logic                hold_mode,
    output logic [NUM_CH-1:0]   alarm,
    output logic [DATA_W-1:0]   disp_min,
    output logic [DATA_W-1:0]   disp_max
);

    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DW_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int F_W     = DATA_W + 4;
    localparam int F_OUT_W = DATA_W + 2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

    typedef enum logic {AUTO, HOLD} state_t;

    // NOTE: reset asserts asynchronously but releases two edges after rst rises, so every
    // downstream flop leaves reset on the same clean edge.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= '0;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    logic [ACC_W-1:0]  acc     [NUM_CH];
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [DATA_W-1:0] avg     [NUM_CH];
    logic [ACC_W-1:0]  sum     [NUM_CH];
    logic [DATA_W-1:0] new_avg [NUM_CH];
    logic [NUM_CH-1:0] avg_ok;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] last;
    logic              ch_ok;

    generate
        if (NUM_CH == (1 << CH_W)) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = (sample_ch < CH_W'(NUM_CH));
        end
    endgenerate

    // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]     = sample_valid && ch_ok && (sample_ch == CH_W'(i));
            last[i]    = (cnt[i] == CNT_LAST);
            sum[i]     = acc[i] + ACC_W'(sample_data);
            new_avg[i] = DATA_W'(sum[i] >> AVG_LOG2);
        end
    end

    // NOTE: the per-channel arrays are real registers, not RAM, so each entry is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
                avg[i] <= '0;
            end
            avg_ok <= '0;
            alarm  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    if (last[i]) begin
                        acc[i]    <= '0;
                        cnt[i]    <= '0;
                        avg[i]    <= new_avg[i];
                        avg_ok[i] <= 1'b1;
                        if (new_avg[i] > hi_thresh)      alarm[i] <= 1'b1;
                        else if (new_avg[i] < lo_thresh) alarm[i] <= 1'b0;
                    end else begin
                        acc[i] <= sum[i];
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    state_t            state, state_nx;
    logic [CH_W-1:0]   disp_ch_nx;
    logic [DW_W-1:0]   dwell, dwell_nx;

    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] ch);
        return (ch == CH_LAST) ? '0 : ch + CH_W'(1);
    endfunction

    // mode_btn has priority; the channel never moves on the cycle the mode toggles.
    always_comb begin
        state_nx   = state;
        disp_ch_nx = disp_ch;
        dwell_nx   = dwell;
        case (state)
            AUTO: begin
                if (mode_btn) begin
                    state_nx = HOLD;
                end else if (dwell == DWELL_LAST) begin
                    dwell_nx   = '0;
                    disp_ch_nx = ch_inc(disp_ch);
                end else begin
                    dwell_nx = dwell + DW_W'(1);
                end
            end
            HOLD: begin
                if (mode_btn) begin
                    state_nx = AUTO;
                    dwell_nx = '0;
                end else if (next_btn) begin
                    disp_ch_nx = ch_inc(disp_ch);
                end
            end
            default: state_nx = AUTO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= AUTO;
            disp_ch <= '0;
            dwell   <= '0;
        end else begin
            state   <= state_nx;
            disp_ch <= disp_ch_nx;
            dwell   <= dwell_nx;
        end
    end

    assign hold_mode = (state == HOLD);

    // Display registers sample the currently selected channel every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_c     <= '0;
            disp_f     <= '0;
            disp_valid <= 1'b0;
        end else begin
            disp_c     <= avg[disp_ch];
            disp_f     <= F_OUT_W'((F_W'(avg[disp_ch]) * F_W'(9)) / F_W'(5) + F_W'(32));
            disp_valid <= avg_ok[disp_ch];
        end
    end

`ifdef TEMP_MON_MINMAX_EN
    logic [DATA_W-1:0] ch_min [NUM_CH];
    logic [DATA_W-1:0] ch_max [NUM_CH];

    // The first commit of a channel (avg_ok still clear) loads both extremes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_min[i] <= '0;
                ch_max[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i] && last[i]) begin
                    if (!avg_ok[i] || (new_avg[i] < ch_min[i])) ch_min[i] <= new_avg[i];
                    if (!avg_ok[i] || (new_avg[i] > ch_max[i])) ch_max[i] <= new_avg[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_min <= '0;
            disp_max <= '0;
        end else begin
            disp_min <= ch_min[disp_ch];
            disp_max <= ch_max[disp_ch];
        end
    end
`else
    assign disp_min = '0;
    assign disp_max = '0;
`endif

endmodule

// File: doc/temp_multi_channel_monitor.md
TEMP_MULTI_CHANNEL_MONITOR -- requirements
Module: temp_multi_channel_monitor

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of sensor channels, 2..16.
REQ-002 The block SHALL have parameter DATA_W, default 8: unsigned Celsius sample width.
REQ-003 The block SHALL have parameter AVG_LOG2, default 2: block-average length of 2^AVG_LOG2 samples, 0..4.
REQ-004 The block SHALL have parameter DWELL_CYCLES, default 25_000_000: clocks per channel in auto-rotate (1 s at 25 MHz).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have sample inputs: sample_valid (1 bit, one-cycle strobe), sample_ch (CH_W = clog2(NUM_CH) bits), sample_data (DATA_W bits).
REQ-008 The block SHALL have control inputs: mode_btn (1 bit, one-cycle pulse, debounced upstream), next_btn (1 bit, one-cycle pulse), hi_thresh (DATA_W bits), lo_thresh (DATA_W bits).
REQ-009 The block SHALL have outputs: disp_ch (CH_W bits), disp_c (DATA_W bits), disp_f (DATA_W+2 bits), disp_valid (1 bit), hold_mode (1 bit), alarm (NUM_CH bits), disp_min (DATA_W bits), disp_max (DATA_W bits).

Function
REQ-010 Each channel SHALL have an accumulator (DATA_W+AVG_LOG2 bits), a sample counter and a registered average avg[ch].
REQ-011 A sample_valid with sample_ch < NUM_CH SHALL add the sample; on the 2^AVG_LOG2-th sample, avg[ch] = (acc+sample)>>AVG_LOG2 (truncating), the accumulator and count clear, and avg_ok[ch] sets (commit).
REQ-012 A sample_valid with sample_ch >= NUM_CH SHALL be ignored.
REQ-013 The display FSM SHALL have states AUTO (reset state) and HOLD; mode_btn toggles AUTO<->HOLD; hold_mode = 1 in HOLD.
REQ-014 In AUTO the dwell counter SHALL run 0..DWELL_CYCLES-1; at the terminal count disp_ch advances, wrapping NUM_CH-1 -> 0, and the counter restarts at 0.
REQ-015 Entering AUTO SHALL clear the dwell counter; disp_ch SHALL stay unchanged on every mode toggle.
REQ-016 In HOLD, next_btn SHALL advance disp_ch with the same wrap; next_btn in AUTO SHALL be ignored.
REQ-017 When mode_btn and next_btn occur in the same cycle, mode_btn SHALL win and next_btn SHALL be ignored.
REQ-018 disp_c, disp_f and disp_valid SHALL be registered from avg[disp_ch]/avg_ok[disp_ch]: one-cycle latency after a commit or a disp_ch change.
REQ-019 disp_f SHALL be (disp_c*9)/5 + 32, truncating, with no overflow at DATA_W+2 bits (255 C -> 491).
REQ-020 alarm[ch] SHALL be evaluated only on a commit: it sets if avg > hi_thresh, clears if avg < lo_thresh, and otherwise holds; set SHALL take priority if both conditions are true.
REQ-021 A commit on a non-displayed channel SHALL NOT disturb the display outputs.

Reset
REQ-022 Asserting rst = 0 SHALL asynchronously clear all accumulators, counters, avg, avg_ok, alarm, disp_ch, disp_c, disp_f, disp_valid, disp_min and disp_max, and SHALL force state AUTO (hold_mode = 0); a partial average in progress is discarded.
REQ-023 Deassertion of rst SHALL be synchronised internally, and the first sample SHALL be accepted no earlier than the second clk edge after release.

Configuration
REQ-024 With TEMP_MON_MINMAX_EN defined, each channel SHALL track min/max of its committed averages; the first commit loads both; disp_min/disp_max follow disp_ch with the same latency as disp_c.
REQ-025 Without TEMP_MON_MINMAX_EN, no min/max storage SHALL be built, and disp_min and disp_max SHALL be constant 0.

Verification (NUM_CH=4, AVG_LOG2=2, DWELL_CYCLES=16)
REQ-026 Samples ch0 = 20,21,22,23 -> one cycle after the 4th: disp_c=21, disp_f=69, disp_valid=1.
REQ-027 Idle in AUTO -> disp_ch steps 0,1,2,3,0 every 16 cycles; disp_valid=0 on channels with no commit.
REQ-028 mode_btn, then next_btn twice, then mode_btn and next_btn together -> HOLD, disp_ch +2, then AUTO with disp_ch unchanged and dwell restarting at 0.
REQ-029 hi=30, lo=25; ch2 averages 31, 28, 24 -> alarm[2] = 1, 1, 0.
REQ-030 rst pulsed low mid-block after 2 of 4 samples, then 4 samples of 40 -> avg=40; partial samples discarded; all outputs 0 during reset.
REQ-031 With TEMP_MON_MINMAX_EN, ch0 averages 30, 10, 50 -> disp_min=10, disp_max=50; without the macro -> both 0.
